// File: rtl/awg_meas_pkg.sv
// Shared types and default widths for the DAC waveform measurement block.
package awg_meas_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meas_state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  period_cycles;
    logic [CNT_W_DEF-1:0]  high_cycles;
    logic [DATA_W_DEF-1:0] min_val;
    logic [DATA_W_DEF-1:0] max_val;
    logic                  timeout;
  } meas_result_t;

endpackage

// File: rtl/level_crossing_detector.sv
// Hysteretic level tracker. The first valid sample after clear sets the level
// against the plain threshold and never reports a rise.
module level_crossing_detector
  import awg_meas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] hi_th,
  input  logic [DATA_W-1:0] lo_th,
  input  logic [DATA_W-1:0] threshold,
  output logic              level,
  output logic              rise
);

  logic level_q, level_d;
  logic init_q, init_d;

  always_comb begin
    level_d = level_q;
    init_d  = init_q;
    if (clear) begin
      level_d = 1'b0;
      init_d  = 1'b0;
    end else if (sample_valid) begin
      init_d = 1'b1;
      if (!init_q)                level_d = (sample_in >= threshold);
      else if (sample_in >= hi_th) level_d = 1'b1;
      else if (sample_in <= lo_th) level_d = 1'b0;
    end
  end

  // level reflects the current sample so the window can count it this cycle
  assign level = level_d;
  assign rise  = sample_valid && !clear && init_q && level_d && !level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      init_q  <= init_d;
    end
  end

endmodule

// File: rtl/dac_waveform_analyzer.sv
// Measures NUM_PERIODS rising-crossing periods of a DAC sample stream and
// returns period, high-time and amplitude extremes over valid/ready.
module dac_waveform_analyzer
  import awg_meas_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int NUM_PERIODS     = 4,
  parameter int TIMEOUT_SAMPLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] threshold,
  input  logic [7:0]        hysteresis,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  period_cycles,
  output logic [CNT_W-1:0]  high_cycles,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic              timeout
);

  localparam int EDGE_W = $clog2(NUM_PERIODS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [DATA_W-1:0] DATA_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [EDGE_W-1:0] EDGE_END = EDGE_W'(NUM_PERIODS);
  localparam logic [TMO_W-1:0]  TMO_END  = TMO_W'(TIMEOUT_SAMPLES);

  meas_state_e       state_q, state_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [7:0]        hys_q, hys_d;
  logic [CNT_W-1:0]  period_q, period_d, high_q, high_d;
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  res_period_q, res_period_d, res_high_q, res_high_d;
  logic [DATA_W-1:0] res_min_q, res_min_d, res_max_q, res_max_d;
  logic              res_tmo_q, res_tmo_d;

  logic [DATA_W:0]   hi_sum, lo_diff;
  logic [DATA_W-1:0] hi_th, lo_th;
  logic              det_clear, level, rise;

  // one extra bit catches overflow above full scale and borrow below zero
  assign hi_sum  = {1'b0, thr_q} + {{(DATA_W-7){1'b0}}, hys_q};
  assign lo_diff = {1'b0, thr_q} - {{(DATA_W-7){1'b0}}, hys_q};
  assign hi_th   = hi_sum[DATA_W]  ? DATA_MAX : hi_sum[DATA_W-1:0];
  assign lo_th   = lo_diff[DATA_W] ? '0       : lo_diff[DATA_W-1:0];

  assign busy         = (state_q == ST_SEEK) || (state_q == ST_MEASURE);
  assign result_valid = (state_q == ST_DONE);
  assign det_clear    = (state_q == ST_IDLE) && arm;

  level_crossing_detector #(.DATA_W(DATA_W)) u_lcd (
    .clk          (clk),
    .rst          (rst),
    .clear        (det_clear),
    .sample_valid (sample_valid & busy),
    .sample_in    (sample_in),
    .hi_th        (hi_th),
    .lo_th        (lo_th),
    .threshold    (thr_q),
    .level        (level),
    .rise         (rise)
  );

  always_comb begin
    state_d      = state_q;
    thr_d        = thr_q;
    hys_d        = hys_q;
    period_d     = period_q;
    high_d       = high_q;
    min_d        = min_q;
    max_d        = max_q;
    edge_d       = edge_q;
    tmo_d        = tmo_q;
    res_period_d = res_period_q;
    res_high_d   = res_high_q;
    res_min_d    = res_min_q;
    res_max_d    = res_max_q;
    res_tmo_d    = res_tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_SEEK;
          thr_d    = threshold;
          hys_d    = hysteresis;
          period_d = '0;
          high_d   = '0;
          min_d    = DATA_MAX;
          max_d    = '0;
          edge_d   = '0;
          tmo_d    = '0;
        end
      end
      ST_SEEK, ST_MEASURE: begin
        if (sample_valid) begin
          tmo_d = tmo_q + 1'b1;
          // timeout reports the window as it stood before this sample
          if (tmo_d == TMO_END) begin
            state_d      = ST_DONE;
            res_period_d = period_q;
            res_high_d   = high_q;
            res_min_d    = min_q;
            res_max_d    = max_q;
            res_tmo_d    = 1'b1;
          end else if (state_q == ST_SEEK) begin
            if (rise) begin
              state_d  = ST_MEASURE;
              period_d = CNT_W'(1);
              high_d   = CNT_W'(1);
              min_d    = sample_in;
              max_d    = sample_in;
              edge_d   = '0;
            end
          end else begin
            if (rise) edge_d = edge_q + 1'b1;
            if (rise && (edge_d == EDGE_END)) begin
              state_d      = ST_DONE;
              res_period_d = period_q;
              res_high_d   = high_q;
              res_min_d    = min_q;
              res_max_d    = max_q;
              res_tmo_d    = 1'b0;
            end else begin
              if (period_q != CNT_MAX)         period_d = period_q + 1'b1;
              if (level && (high_q != CNT_MAX)) high_d  = high_q + 1'b1;
              if (sample_in < min_q)            min_d   = sample_in;
              if (sample_in > max_q)            max_d   = sample_in;
            end
          end
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      thr_q        <= '0;
      hys_q        <= '0;
      period_q     <= '0;
      high_q       <= '0;
      min_q        <= DATA_MAX;
      max_q        <= '0;
      edge_q       <= '0;
      tmo_q        <= '0;
      res_period_q <= '0;
      res_high_q   <= '0;
      res_min_q    <= DATA_MAX;
      res_max_q    <= '0;
      res_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      thr_q        <= thr_d;
      hys_q        <= hys_d;
      period_q     <= period_d;
      high_q       <= high_d;
      min_q        <= min_d;
      max_q        <= max_d;
      edge_q       <= edge_d;
      tmo_q        <= tmo_d;
      res_period_q <= res_period_d;
      res_high_q   <= res_high_d;
      res_min_q    <= res_min_d;
      res_max_q    <= res_max_d;
      res_tmo_q    <= res_tmo_d;
    end
  end

  assign period_cycles = res_period_q;
  assign high_cycles   = res_high_q;
  assign min_val       = res_min_q;
  assign max_val       = res_max_q;
  assign timeout       = res_tmo_q;

endmodule

// File: tb/tb_dac_waveform_analyzer.sv
// Scenario bench for dac_waveform_analyzer: square, sawtooth, timeout,
// backpressure, mid-run reset and ignored arm pulses.
module tb_dac_waveform_analyzer;

  logic        clk = 1'b0;
  logic        rst, arm, sample_valid, result_ready;
  logic        busy, result_valid, timeout;
  logic [11:0] threshold, sample_in, min_val, max_val;
  logic [7:0]  hysteresis;
  logic [31:0] period_cycles, high_cycles;
  logic [88:0] got_rec, exp_r, snap;
  logic [88:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  int wmode = 0;
  int widx  = 0;
  bit alt   = 1'b0;
  bit phase = 1'b0;
  bit got;

  always #5 clk = ~clk;

  dac_waveform_analyzer #(
    .NUM_PERIODS     (4),
    .TIMEOUT_SAMPLES (1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .threshold     (threshold),
    .hysteresis    (hysteresis),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .period_cycles (period_cycles),
    .high_cycles   (high_cycles),
    .min_val       (min_val),
    .max_val       (max_val),
    .timeout       (timeout)
  );

  assign got_rec = {period_cycles, high_cycles, min_val, max_val, timeout};

  function automatic logic [88:0] rec(int p, int h, int mn, int mx, bit t);
    return {32'(p), 32'(h), 12'(mn), 12'(mx), t};
  endfunction

  function automatic logic [11:0] wave(int mode, int idx);
    case (mode)
      1:       return ((idx % 100) < 25) ? 12'd3000 : 12'd1000;
      2:       return 12'((idx % 64) * 64);
      default: return 12'(2037 + $urandom_range(6));
    endcase
  endfunction

  // all tasks start and end just after a falling edge
  task automatic drive_next();
    phase        = alt ? ~phase : 1'b1;
    sample_valid = phase;
    sample_in    = phase ? wave(wmode, widx) : 12'd0;
    if (phase) widx++;
    @(negedge clk);
  endtask

  task automatic start(int mode, logic [11:0] th, logic [7:0] hy, bit a);
    arm          = 1'b1;
    threshold    = th;
    hysteresis   = hy;
    sample_valid = 1'b0;
    @(negedge clk);
    arm   = 1'b0;
    wmode = mode;
    widx  = 0;
    alt   = a;
    phase = 1'b0;
  endtask

  task automatic run_until(int max_cycles, int arm_at, output bit done);
    done = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (result_valid) begin
        done = 1'b1;
        break;
      end
      arm = (c == arm_at);
      if (c == arm_at) threshold = 12'd500;
      drive_next();
    end
    if (!done && result_valid) done = 1'b1;
    arm          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, result_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_flags busy/valid got=%b exp=00", {busy, result_valid});
    end
    total++;
    if (got_rec !== rec(0, 0, 4095, 0, 0)) begin
      bad++; $display("FAIL reset_rec got=%h exp=%h", got_rec, rec(0, 0, 4095, 0, 0));
    end
  endtask

  task automatic test_square();
    exp_q.push_back(rec(400, 100, 1000, 3000, 0));
    start(1, 12'd2048, 8'd16, 1'b0);
    run_until(2000, -1, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL square_done got=%b exp=1", got); end
    total++;
    if (widx != 501) begin bad++; $display("FAIL square_latency samples got=%0d exp=501", widx); end
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL square_rec got=%h exp=%h", got_rec, exp_r); end
    accept();
    total++;
    if ({busy, result_valid} !== 2'b00) begin
      bad++; $display("FAIL square_handshake busy/valid got=%b exp=00", {busy, result_valid});
    end
  endtask

  task automatic test_sawtooth();
    exp_q.push_back(rec(256, 128, 0, 4032, 0));
    start(2, 12'd2048, 8'd0, 1'b1);
    run_until(3000, -1, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL saw_done got=%b exp=1", got); end
    total++;
    if (widx != 289) begin bad++; $display("FAIL saw_latency samples got=%0d exp=289", widx); end
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL saw_rec got=%h exp=%h", got_rec, exp_r); end
    accept();
  endtask

  task automatic test_timeout();
    exp_q.push_back(rec(0, 0, 4095, 0, 1));
    start(3, 12'd2048, 8'd8, 1'b0);
    run_until(1500, -1, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL tmo_done got=%b exp=1", got); end
    total++;
    if (widx != 1000) begin bad++; $display("FAIL tmo_samples got=%0d exp=1000", widx); end
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL tmo_rec got=%h exp=%h", got_rec, exp_r); end
    accept();
  endtask

  task automatic test_backpressure();
    exp_q.push_back(rec(400, 100, 1000, 3000, 0));
    start(1, 12'd2048, 8'd16, 1'b0);
    run_until(2000, -1, got);
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL bp_rec got=%h exp=%h", got_rec, exp_r); end
    for (int i = 0; i < 50; i++) begin
      drive_next();
      total++;
      if ({result_valid, got_rec} !== {1'b1, exp_r}) begin
        bad++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h exp=%h", i, result_valid, got_rec, exp_r);
      end
    end
    sample_valid = 1'b0;
    accept();
    total++;
    if ({busy, result_valid} !== 2'b00) begin
      bad++; $display("FAIL bp_release busy/valid got=%b exp=00", {busy, result_valid});
    end
    exp_q.push_back(rec(400, 100, 1000, 3000, 0));
    start(1, 12'd2048, 8'd16, 1'b0);
    run_until(2000, -1, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL bp_rearm_done got=%b exp=1", got); end
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL bp_rearm_rec got=%h exp=%h", got_rec, exp_r); end
    accept();
  endtask

  task automatic test_reset_mid();
    start(1, 12'd2048, 8'd16, 1'b0);
    run_until(250, -1, got);
    total++;
    if ({got, busy} !== 2'b01) begin
      bad++; $display("FAIL rstmid_running done/busy got=%b exp=01", {got, busy});
    end
    rst = 1'b1;
    arm = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    arm = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, result_valid} !== 2'b00) begin
      bad++; $display("FAIL rstmid_flags busy/valid got=%b exp=00", {busy, result_valid});
    end
    total++;
    if (got_rec !== rec(0, 0, 4095, 0, 0)) begin
      bad++; $display("FAIL rstmid_rec got=%h exp=%h", got_rec, rec(0, 0, 4095, 0, 0));
    end
    exp_q.push_back(rec(400, 100, 1000, 3000, 0));
    start(1, 12'd2048, 8'd16, 1'b0);
    run_until(2000, -1, got);
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL rstmid_fresh got=%h exp=%h", got_rec, exp_r); end
    accept();
  endtask

  task automatic test_arm_ignored();
    exp_q.push_back(rec(400, 100, 1000, 3000, 0));
    start(1, 12'd2048, 8'd16, 1'b0);
    run_until(2000, 200, got);
    total++;
    if (widx != 501) begin bad++; $display("FAIL armign_restart samples got=%0d exp=501", widx); end
    exp_r = exp_q.pop_front();
    total++;
    if (got_rec !== exp_r) begin bad++; $display("FAIL armign_rec got=%h exp=%h", got_rec, exp_r); end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    total++;
    if ({result_valid, got_rec} !== {1'b1, exp_r}) begin
      bad++; $display("FAIL armign_done valid=%b got=%h exp=%h", result_valid, got_rec, exp_r);
    end
    arm          = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    arm          = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, result_valid} !== 2'b00) begin
      bad++; $display("FAIL armign_handoff busy/valid got=%b exp=00", {busy, result_valid});
    end
  endtask

  initial begin
    rst          = 1'b1;
    arm          = 1'b0;
    threshold    = 12'd0;
    hysteresis   = 8'd0;
    sample_in    = 12'd0;
    sample_valid = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_square();
    test_sawtooth();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_arm_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
